trace_packer: RTL and testbench
===============================

# trace_packer

Front end of the debug trace buffer: samples up to `TRB_MAX_TRACES` trace signals every enabled cycle and packs the samples LSB-first into `TRB_WIDTH`-bit words. Each completed word is handed to the downstream trace logger through the store/permission handshake. The packer also tags the word that contains the first trigger sample with the trigger's bit position. Capture stops when the logger reports that the delayed trigger has expired.

## Interface
- `TRB_WIDTH`, 32, packed word width; must be a power of two and at least `TRB_MAX_TRACES`.
- `TRB_MAX_TRACES`, 8, maximum sample width in bits; must be a power of two.
- `TRB_NTRACE_BITS`, `$clog2($clog2(TRB_MAX_TRACES)+1)`, width of the sample-width selector.
- `CLK_I` in 1: single clock; all logic is on its rising edge.
- `RST_I` in 1: reset, asynchronous and active-high.
- `ENABLE_I` in 1: capture enable (arm).
- `TRACE_I` in `TRB_MAX_TRACES`: raw trace sample; only the low `w` bits are used.
- `TRG_I` in 1: trigger condition, sampled together with `TRACE_I`.
- `NTRACE_I` in `TRB_NTRACE_BITS`: sample width `w = 2**NTRACE_I`; values that give `w > TRB_MAX_TRACES` are clamped to `TRB_MAX_TRACES`.
- `TRG_DELAYED_I` in 1: the logger's post-trigger delay has expired; stop capture.
- `STORE_PERM_I` in 1: the logger accepts a store in this cycle.
- `STORE_O` out 1: single-cycle store strobe.
- `DATA_O` out `TRB_WIDTH`: word being stored; valid while `STORE_O` is high.
- `TRG_EVENT_O` out 1: the stored word carries the trigger; qualified by `STORE_O`.
- `EVENT_POS_O` out `$clog2(TRB_WIDTH)`: bit index of the trigger sample's LSB; qualified by `TRG_EVENT_O`.
- `OVERFLOW_O` out 1: sticky flag; at least one word has been dropped.
- `BUSY_O` out 1: high while the packer is in state CAPTURE.

## Operation
- FSM states are IDLE, CAPTURE and STOPPED. Reset enters IDLE.
- IDLE → CAPTURE when `ENABLE_I` is high. On this transition the packer latches `w` from `NTRACE_I`, clears the sample index `k` and the partial word, and arms the trigger. A later change on `NTRACE_I` has no effect until the next entry into CAPTURE.
- In CAPTURE, each cycle:
  - `TRACE_I[w-1:0]` is written to `shift[k*w +: w]`.
  - `k` increments and wraps at `TRB_WIDTH/w`.
  - On the last sample the completed word moves to the holding register (`hold`, `hold_valid`).
- Trigger tagging:
  - The first `TRG_I=1` sampled in CAPTURE after arming records `pos = k*w` and disarms the trigger.
  - The trigger stays pending until a word is loaded into `hold`. That word then carries `trg=1` and `pos`.
- Exits from CAPTURE:
  - CAPTURE → STOPPED when `TRG_DELAYED_I` is high. The partial word is discarded; a pending `hold` still drains.
  - CAPTURE → IDLE when `ENABLE_I` is low. The partial word is discarded.
  - `TRG_DELAYED_I` has priority over `ENABLE_I`.
- STOPPED → IDLE only when `ENABLE_I` is low and `TRG_DELAYED_I` is low.
- Store handshake:
  - `STORE_O = hold_valid & STORE_PERM_I`, a combinational function of the register and the input.
  - `DATA_O = hold`. `TRG_EVENT_O = hold_trg & STORE_O`. `EVENT_POS_O = hold_pos`.
  - `hold_valid` clears on the edge where `STORE_O` is high.
- Overflow:
  - A word completes while `hold_valid` is set and `STORE_O` is low → the new word is dropped and `OVERFLOW_O` is set.
  - If the dropped word carried the trigger, the trigger tag is lost. The trigger is not re-reported.
  - If `STORE_O` is high on that same edge, `hold` is refilled and nothing is dropped.
- Reset values: all outputs 0 (`STORE_O`, `DATA_O`, `TRG_EVENT_O`, `EVENT_POS_O`, `OVERFLOW_O`, `BUSY_O`). `hold_valid` = 0, `k` = 0, state = IDLE.
- `OVERFLOW_O` is cleared only by reset.
- Reset asserted mid-word or mid-handshake clears all state immediately. No store is issued for pending data.

## Timing
- `TRACE_I` and `TRG_I` are sampled on the first edge after CAPTURE is entered. With `ENABLE_I` rising before edge 0, the first sample is taken at edge 1.
- For `n = TRB_WIDTH/w`: the word is complete at the n-th sample edge, `hold_valid` is visible in the following cycle, and `STORE_O` can be high in that same cycle. Latency from the last sample to the store is 1 cycle.
- Sustained throughput is one word per `n` cycles. One holding register absorbs `n-1` cycles of `STORE_PERM_I` being low without loss.
- `BUSY_O` is registered and tracks the state with no extra delay.

## Structure
- DTB_PKG holds: `TRB_WIDTH`, `TRB_MAX_TRACES`, `TRB_NTRACE_BITS`, the state enum `packer_state_t`, and a struct `packed_word_t` {data, trg, pos} used by `hold`.
- One sub-module, `trace_word_hold`: the single-entry holding register with the overflow and drop logic.
- The FSM and the shift packer stay in the top module.

## Test plan
- Reset check: assert `RST_I` mid-capture with `hold_valid`=1 → all outputs 0 in the next cycle; no `STORE_O` after release until a new full word is captured.
- Packing at `w`=8, width 32: `TRACE_I` = 0x11, 0x22, 0x33, 0x44 with perm held at 1 → `STORE_O` for one cycle, 1 cycle after the 4th sample, with `DATA_O`=0x44332211.
- Width sweep: `NTRACE_I` = 0, 1, 2, 3 → one store every 32, 16, 8, 4 samples; `NTRACE_I` changed mid-capture → no effect.
- Trigger tagging at `w`=4: `TRG_I` high on the 3rd sample → the stored word has `TRG_EVENT_O`=1 and `EVENT_POS_O`=8; a second `TRG_I` produces no further tag.
- Backpressure at `w`=8: `STORE_PERM_I`=0 for 3 cycles → no loss. Held 0 for 4 or more cycles → one word dropped and `OVERFLOW_O`=1 (sticky).
- Stop: `TRG_DELAYED_I` raised mid-word → STOPPED and `BUSY_O`=0; the pending `hold` drains; no further stores; returns to IDLE after `ENABLE_I` and `TRG_DELAYED_I` go low.

Source files
------------

// File: rtl/dtb_pkg.sv
// Shared widths, FSM state encoding and the packed-word record used by the
// debug trace buffer front end.
package dtb_pkg;

   localparam int TRB_WIDTH       = 32;
   localparam int TRB_MAX_TRACES  = 8;
   localparam int TRB_NTRACE_BITS = $clog2($clog2(TRB_MAX_TRACES) + 1);
   localparam int TRB_POS_BITS    = $clog2(TRB_WIDTH);
   localparam int TRB_MAX_WLOG    = $clog2(TRB_MAX_TRACES);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      STOPPED
   } packer_state_t;

   typedef struct packed {
      logic [TRB_WIDTH-1:0]    data;
      logic                    trg;
      logic [TRB_POS_BITS-1:0] pos;
   } packed_word_t;

   // Selector values asking for more lanes than exist fall back to the widest sample.
   function automatic logic [TRB_NTRACE_BITS-1:0] clampWlog(input logic [TRB_NTRACE_BITS-1:0] ntrace);
      if (int'(ntrace) > TRB_MAX_WLOG) begin
         return TRB_NTRACE_BITS'(TRB_MAX_WLOG);
      end
      return ntrace;
   endfunction

   function automatic logic [TRB_POS_BITS-1:0] lastIndex(input logic [TRB_NTRACE_BITS-1:0] wlog);
      return TRB_POS_BITS'((TRB_WIDTH >> wlog) - 1);
   endfunction

endpackage

// File: rtl/trace_word_hold.sv
// Single-entry holding register between the packer and the trace logger.
// A completed word is dropped (and the sticky overflow raised) when the slot is full and not draining.
module trace_word_hold
   import dtb_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  packed_word_t word_i,
   input  logic         perm_i,
   output logic         store_o,
   output packed_word_t word_o,
   output logic         overflow_o
);

   packed_word_t holdWord_q;
   logic         holdValid_q;
   logic         overflow_q;

   assign store_o    = holdValid_q & perm_i;
   assign word_o     = holdWord_q;
   assign overflow_o = overflow_q;

   // A store on the same edge frees the slot, so a simultaneous push refills it instead of dropping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         holdWord_q  <= '0;
         holdValid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         if (push_i && (!holdValid_q || store_o)) begin
            holdWord_q  <= word_i;
            holdValid_q <= 1'b1;
         end else if (push_i) begin
            overflow_q  <= 1'b1;
         end else if (store_o) begin
            holdValid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/trace_packer.sv
// Trace packer: samples 2**NTRACE_I trace bits per enabled cycle, packs them LSB-first
// into words, tags the word holding the first trigger and hands words to the logger.
module trace_packer
   import dtb_pkg::*;
(
   input  logic                       CLK_I,
   input  logic                       RST_I,
   input  logic                       ENABLE_I,
   input  logic [TRB_MAX_TRACES-1:0]  TRACE_I,
   input  logic                       TRG_I,
   input  logic [TRB_NTRACE_BITS-1:0] NTRACE_I,
   input  logic                       TRG_DELAYED_I,
   input  logic                       STORE_PERM_I,
   output logic                       STORE_O,
   output logic [TRB_WIDTH-1:0]       DATA_O,
   output logic                       TRG_EVENT_O,
   output logic [TRB_POS_BITS-1:0]    EVENT_POS_O,
   output logic                       OVERFLOW_O,
   output logic                       BUSY_O
);

   packer_state_t               state_q;
   logic                        busy_q;
   logic [TRB_NTRACE_BITS-1:0]  wlog_q;
   logic [TRB_POS_BITS-1:0]     k_q;
   logic [TRB_WIDTH-1:0]        shift_q;
   logic                        armed_q;
   logic                        trgPending_q;
   logic [TRB_POS_BITS-1:0]     trgPos_q;

   logic [TRB_POS_BITS:0]       sampleW;
   logic [TRB_MAX_TRACES-1:0]   laneMask;
   logic [TRB_POS_BITS-1:0]     bitOff;
   logic [TRB_WIDTH-1:0]        sampleMask;
   logic [TRB_WIDTH-1:0]        sampleData;
   logic [TRB_WIDTH-1:0]        shift_d;
   logic                        sampling;
   logic                        lastSample;
   logic                        trgFire;
   logic                        wordPush;
   packed_word_t                pushWord;
   packed_word_t                holdWord;

   // The completed word must include the sample taken on the completing edge, hence shift_d.
   always_comb begin
      sampleW = (TRB_POS_BITS + 1)'(1) << wlog_q;
      for (int i = 0; i < TRB_MAX_TRACES; i++) begin
         laneMask[i] = (i < int'(sampleW));
      end
      bitOff     = k_q << wlog_q;
      sampleMask = TRB_WIDTH'(laneMask) << bitOff;
      sampleData = TRB_WIDTH'(TRACE_I & laneMask) << bitOff;
      shift_d    = (shift_q & ~sampleMask) | sampleData;
      sampling   = (state_q == CAPTURE) && !TRG_DELAYED_I && ENABLE_I;
      lastSample = (k_q == lastIndex(wlog_q));
      trgFire    = sampling && armed_q && TRG_I;
      wordPush   = sampling && lastSample;
      pushWord.data = shift_d;
      pushWord.trg  = trgPending_q | trgFire;
      pushWord.pos  = trgFire ? bitOff : trgPos_q;
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         wlog_q       <= '0;
         k_q          <= '0;
         shift_q      <= '0;
         armed_q      <= 1'b0;
         trgPending_q <= 1'b0;
         trgPos_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ENABLE_I) begin
                  state_q      <= CAPTURE;
                  busy_q       <= 1'b1;
                  wlog_q       <= clampWlog(NTRACE_I);
                  k_q          <= '0;
                  shift_q      <= '0;
                  armed_q      <= 1'b1;
                  trgPending_q <= 1'b0;
               end
            end
            CAPTURE: begin
               if (TRG_DELAYED_I) begin
                  state_q <= STOPPED;
                  busy_q  <= 1'b0;
               end else if (!ENABLE_I) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  shift_q <= shift_d;
                  k_q     <= lastSample ? '0 : k_q + 1'b1;
                  if (trgFire) begin
                     armed_q  <= 1'b0;
                     trgPos_q <= bitOff;
                  end
                  // Any word push consumes the pending tag, even one the hold slot then drops.
                  trgPending_q <= wordPush ? 1'b0 : (trgPending_q | trgFire);
               end
            end
            STOPPED: begin
               if (!ENABLE_I && !TRG_DELAYED_I) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   trace_word_hold uHold (
      .clk_i      (CLK_I),
      .rst_i      (RST_I),
      .push_i     (wordPush),
      .word_i     (pushWord),
      .perm_i     (STORE_PERM_I),
      .store_o    (STORE_O),
      .word_o     (holdWord),
      .overflow_o (OVERFLOW_O)
   );

   assign DATA_O      = holdWord.data;
   assign TRG_EVENT_O = holdWord.trg & STORE_O;
   assign EVENT_POS_O = holdWord.pos;
   assign BUSY_O      = busy_q;

endmodule

// File: tb/tb_trace_packer.sv
// Self-checking bench for trace_packer: expected words go into a scoreboard queue
// as samples are driven and are compared whenever the packer issues a store.
module tb_trace_packer;
   import dtb_pkg::*;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       enable;
   logic [TRB_MAX_TRACES-1:0]  trace;
   logic                       trg;
   logic [TRB_NTRACE_BITS-1:0] ntrace;
   logic                       trgDelayed;
   logic                       storePerm;
   logic                       store;
   logic [TRB_WIDTH-1:0]       data;
   logic                       trgEvent;
   logic [TRB_POS_BITS-1:0]    eventPos;
   logic                       overflow;
   logic                       busy;

   int checks = 0;
   int errors = 0;
   int storeCount = 0;

   typedef struct {
      logic [31:0] data;
      logic        trg;
      logic [4:0]  pos;
   } expWord_t;

   expWord_t expQ[$];

   typedef struct {
      logic [1:0] ntr;
      logic [1:0] ntrLate;
      int         spw;
   } sweepVec_t;

   sweepVec_t sweep[4];

   always #5 clk = ~clk;

   trace_packer dut (
      .CLK_I         (clk),
      .RST_I         (rst),
      .ENABLE_I      (enable),
      .TRACE_I       (trace),
      .TRG_I         (trg),
      .NTRACE_I      (ntrace),
      .TRG_DELAYED_I (trgDelayed),
      .STORE_PERM_I  (storePerm),
      .STORE_O       (store),
      .DATA_O        (data),
      .TRG_EVENT_O   (trgEvent),
      .EVENT_POS_O   (eventPos),
      .OVERFLOW_O    (overflow),
      .BUSY_O        (busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] t, input logic tg, input logic perm);
      trace     = t;
      trg       = tg;
      storePerm = perm;
      tick();
   endtask

   task automatic startCapture(input logic [1:0] ntr);
      ntrace = ntr;
      enable = 1'b1;
      tick();
      checkOutput("busy after entry", 32'(busy), 32'd1);
   endtask

   task automatic stopCapture(input string name);
      enable    = 1'b0;
      trace     = '0;
      trg       = 1'b0;
      storePerm = 1'b1;
      repeat (4) tick();
      checkOutput({name, " pending stores"}, 32'(expQ.size()), 32'd0);
      checkOutput({name, " busy after stop"}, 32'(busy), 32'd0);
   endtask

   // Each store pops the oldest expected word; a store with nothing expected is an error.
   always @(negedge clk) begin : monitor
      expWord_t e;
      if (!rst && store) begin
         storeCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected store", 32'(store), 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("store data", data, e.data);
            checkOutput("store trg", 32'(trgEvent), 32'(e.trg));
            if (e.trg) begin
               checkOutput("store pos", 32'(eventPos), 32'(e.pos));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0]  t;
      logic [7:0]  mask;
      logic [31:0] modelWord;
      int          w;
      int          spw;
      int          storeBase;

      sweep[0] = '{2'd0, 2'd3, 32};
      sweep[1] = '{2'd1, 2'd2, 16};
      sweep[2] = '{2'd2, 2'd0, 8};
      sweep[3] = '{2'd3, 2'd1, 4};

      rst        = 1'b1;
      enable     = 1'b0;
      trace      = '0;
      trg        = 1'b0;
      ntrace     = '0;
      trgDelayed = 1'b0;
      storePerm  = 1'b1;
      repeat (2) tick();
      checkOutput("reset store", 32'(store), 32'd0);
      checkOutput("reset data", data, 32'd0);
      checkOutput("reset trg event", 32'(trgEvent), 32'd0);
      checkOutput("reset event pos", 32'(eventPos), 32'd0);
      checkOutput("reset overflow", 32'(overflow), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();

      $display("[TB] packing at w=8");
      startCapture(2'd3);
      expQ.push_back('{32'h44332211, 1'b0, 5'd0});
      applyStimulus(8'h11, 1'b0, 1'b1);
      applyStimulus(8'h22, 1'b0, 1'b1);
      applyStimulus(8'h33, 1'b0, 1'b1);
      checkOutput("store before 4th sample", 32'(store), 32'd0);
      applyStimulus(8'h44, 1'b0, 1'b1);
      checkOutput("store after 4th sample", 32'(store), 32'd1);
      checkOutput("packed word", data, 32'h44332211);
      enable = 1'b0;
      tick();
      checkOutput("store single cycle", 32'(store), 32'd0);
      stopCapture("pack8");

      $display("[TB] width sweep");
      for (int v = 0; v < 4; v++) begin
         startCapture(sweep[v].ntr);
         ntrace    = sweep[v].ntrLate;
         w         = 1 << sweep[v].ntr;
         spw       = sweep[v].spw;
         mask      = 8'((9'd1 << w) - 1);
         modelWord = '0;
         for (int i = 0; i < 2 * spw; i++) begin
            t = 8'($urandom);
            modelWord |= 32'(t & mask) << ((i % spw) * w);
            if ((i % spw) == spw - 1) begin
               expQ.push_back('{modelWord, 1'b0, 5'd0});
               modelWord = '0;
            end
            applyStimulus(t, 1'b0, 1'b1);
            checkOutput($sformatf("sweep w%0d store after sample %0d", w, i),
                        32'(store), 32'((i % spw) == spw - 1));
         end
         stopCapture($sformatf("sweep w%0d", w));
      end

      $display("[TB] trigger tagging at w=4");
      startCapture(2'd2);
      modelWord = '0;
      for (int i = 0; i < 16; i++) begin
         t = 8'($urandom);
         modelWord |= 32'(t & 8'h0f) << ((i % 8) * 4);
         if (i == 7) begin
            expQ.push_back('{modelWord, 1'b1, 5'd8});
            modelWord = '0;
         end else if (i == 15) begin
            expQ.push_back('{modelWord, 1'b0, 5'd0});
         end
         applyStimulus(t, (i == 2) || (i == 9), 1'b1);
         if (i == 7) begin
            checkOutput("trigger event tagged", 32'(trgEvent), 32'd1);
            checkOutput("trigger position", 32'(eventPos), 32'd8);
         end else if (i == 15) begin
            checkOutput("second trigger not tagged", 32'(trgEvent), 32'd0);
         end
      end
      stopCapture("trigger");

      $display("[TB] backpressure for 3 cycles");
      startCapture(2'd3);
      modelWord = '0;
      for (int i = 0; i < 8; i++) begin
         t = 8'($urandom);
         modelWord |= 32'(t) << ((i % 4) * 8);
         if ((i % 4) == 3) begin
            expQ.push_back('{modelWord, 1'b0, 5'd0});
            modelWord = '0;
         end
         applyStimulus(t, 1'b0, !(i >= 4 && i <= 6));
      end
      checkOutput("no overflow after 3 stalled cycles", 32'(overflow), 32'd0);
      stopCapture("stall3");

      $display("[TB] backpressure for 4 cycles");
      startCapture(2'd3);
      modelWord = '0;
      for (int i = 0; i < 12; i++) begin
         t = 8'($urandom);
         modelWord |= 32'(t) << ((i % 4) * 8);
         if ((i % 4) == 3) begin
            if (i != 7) begin
               expQ.push_back('{modelWord, 1'b0, 5'd0});
            end
            modelWord = '0;
         end
         applyStimulus(t, 1'b0, !(i >= 4 && i <= 7));
         if (i == 7) begin
            checkOutput("overflow after drop", 32'(overflow), 32'd1);
         end
      end
      stopCapture("stall4");
      checkOutput("overflow sticky", 32'(overflow), 32'd1);

      $display("[TB] stop on delayed trigger");
      startCapture(2'd3);
      modelWord = '0;
      for (int i = 0; i < 6; i++) begin
         t = 8'($urandom);
         if (i < 4) begin
            modelWord |= 32'(t) << (i * 8);
         end
         applyStimulus(t, 1'b0, 1'b0);
      end
      checkOutput("held word not stored under stall", 32'(store), 32'd0);
      trgDelayed = 1'b1;
      tick();
      checkOutput("busy low in stopped", 32'(busy), 32'd0);
      storeBase = storeCount;
      expQ.push_back('{modelWord, 1'b0, 5'd0});
      for (int i = 0; i < 8; i++) begin
         applyStimulus(8'($urandom), 1'b0, 1'b1);
      end
      checkOutput("stores while stopped", 32'(storeCount - storeBase), 32'd1);
      checkOutput("stopped drain queue", 32'(expQ.size()), 32'd0);
      enable = 1'b0;
      tick();
      enable = 1'b1;
      tick();
      checkOutput("stopped holds while delayed", 32'(busy), 32'd0);
      enable = 1'b0;
      tick();
      trgDelayed = 1'b0;
      tick();
      startCapture(2'd3);
      stopCapture("restart after stop");

      $display("[TB] reset mid-handshake");
      startCapture(2'd3);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(8'hA0 + 8'(i), 1'b0, 1'b0);
      end
      rst       = 1'b1;
      storePerm = 1'b1;
      #1;
      checkOutput("mid reset store", 32'(store), 32'd0);
      checkOutput("mid reset data", data, 32'd0);
      checkOutput("mid reset trg event", 32'(trgEvent), 32'd0);
      checkOutput("mid reset event pos", 32'(eventPos), 32'd0);
      checkOutput("mid reset overflow", 32'(overflow), 32'd0);
      checkOutput("mid reset busy", 32'(busy), 32'd0);
      enable = 1'b0;
      repeat (2) tick();
      rst       = 1'b0;
      storeBase = storeCount;
      repeat (4) tick();
      checkOutput("no store after reset", 32'(storeCount - storeBase), 32'd0);
      startCapture(2'd3);
      expQ.push_back('{32'h0D0C0B0A, 1'b0, 5'd0});
      applyStimulus(8'h0A, 1'b0, 1'b1);
      applyStimulus(8'h0B, 1'b0, 1'b1);
      applyStimulus(8'h0C, 1'b0, 1'b1);
      applyStimulus(8'h0D, 1'b0, 1'b1);
      stopCapture("after reset");
      checkOutput("stores after reset", 32'(storeCount - storeBase), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
